// File: rtl/soc_ahb4_pkg.sv
// Shared AHB4-Lite encodings and the external responder state type.
package soc_ahb4_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_B8  = 3'b000;
  localparam logic [2:0] HSIZE_B16 = 3'b001;
  localparam logic [2:0] HSIZE_B32 = 3'b010;
  localparam logic [2:0] HSIZE_B64 = 3'b011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Responder data-phase sequencing: zero-wait, wait-stated, or the two ERROR cycles.
  typedef enum logic [1:0] {
    RSP_IDLE,
    RSP_WAIT,
    RSP_ERR1,
    RSP_ERR2
  } rsp_state_t;

endpackage

// File: rtl/mpsoc_ahb4_be_gen.sv
// Byte-enable generator: turns an AHB transfer size and the low address bits into
// little-endian byte lanes, and flags sizes wider than the bus or misaligned addresses.
module mpsoc_ahb4_be_gen
  import soc_ahb4_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                  hsize,
  input  logic [$clog2(XLEN/8)-1:0]   addr_lo,
  output logic [XLEN/8-1:0]           be,
  output logic                        misalign,
  output logic                        oversize
);

  localparam int BYTES = XLEN / 8;
  localparam int OFFW  = $clog2(BYTES);

  // Lanes are only produced for legal, aligned transfers; anything else leaves them clear.
  always_comb begin
    be       = '0;
    misalign = 1'b0;
    oversize = (hsize > 3'(OFFW));
    if (!oversize) begin
      for (int i = 0; i < OFFW; i++) begin
        if ((i < int'(hsize)) && addr_lo[i]) misalign = 1'b1;
      end
      if (!misalign) begin
        for (int b = 0; b < BYTES; b++) begin
          if ((b >= int'(addr_lo)) && (b < int'(addr_lo) + (1 << hsize))) be[b] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mpsoc_ahb4_ext_responder.sv
// AHB4-Lite slave terminating an external port: local word memory with optional
// wait states, byte/halfword/word writes and a forced-error address window.
module mpsoc_ahb4_ext_responder
  import soc_ahb4_pkg::*;
#(
  parameter int              PLEN        = 32,
  parameter int              XLEN        = 32,
  parameter int              MEM_DEPTH   = 1024,
  parameter logic [PLEN-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int              WAIT_STATES = 0,
  parameter logic [PLEN-1:0] ERR_BASE    = 32'hF000_0000,
  parameter logic [PLEN-1:0] ERR_SIZE    = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ahb4_hsel_i,
  input  logic [PLEN-1:0] ahb4_haddr_i,
  input  logic [XLEN-1:0] ahb4_hwdata_i,
  input  logic            ahb4_hwrite_i,
  input  logic [2:0]      ahb4_hsize_i,
  input  logic [2:0]      ahb4_hburst_i,
  input  logic [3:0]      ahb4_hprot_i,
  input  logic [1:0]      ahb4_htrans_i,
  input  logic            ahb4_hmastlock_i,
  input  logic            ahb4_hready_i,
  output logic [XLEN-1:0] ahb4_hrdata_o,
  output logic            ahb4_hreadyout_o,
  output logic            ahb4_hresp_o,
  output logic [15:0]     err_cnt_o
);

  localparam int              BYTES     = XLEN / 8;
  localparam int              OFFW      = $clog2(BYTES);
  localparam int              IDXW      = $clog2(MEM_DEPTH);
  localparam logic [PLEN:0]   MEM_BYTES = (PLEN+1)'(MEM_DEPTH * BYTES);

  rsp_state_t        state, state_d;
  logic [3:0]        wait_cnt, wait_cnt_d;
  logic              err_inc;
  logic              hreadyout;

  logic [PLEN:0]     mem_off, err_off;
  logic              in_mem, in_err, err_flag, accept, commit;
  logic [BYTES-1:0]  be;
  logic              misalign, oversize;

  logic              dp_valid, dp_write;
  logic [IDXW-1:0]   dp_idx;
  logic [BYTES-1:0]  dp_be;
  logic [15:0]       err_cnt;

  logic [XLEN-1:0]   mem [MEM_DEPTH];

  // Burst type, protection and lock carry no meaning for this terminator.
  logic unused_inputs;
  assign unused_inputs = ^{ahb4_hburst_i, ahb4_hprot_i, ahb4_hmastlock_i};

  mpsoc_ahb4_be_gen #(.XLEN(XLEN)) u_be_gen (
    .hsize    (ahb4_hsize_i),
    .addr_lo  (ahb4_haddr_i[OFFW-1:0]),
    .be       (be),
    .misalign (misalign),
    .oversize (oversize)
  );

  // Address-phase decode: memory range, forced-error window and size/alignment legality.
  always_comb begin
    mem_off  = {1'b0, ahb4_haddr_i} - {1'b0, BASE_ADDR};
    err_off  = {1'b0, ahb4_haddr_i} - {1'b0, ERR_BASE};
    in_mem   = (ahb4_haddr_i >= BASE_ADDR) && (mem_off < MEM_BYTES);
    in_err   = (ERR_SIZE != '0) && (ahb4_haddr_i >= ERR_BASE) && (err_off < {1'b0, ERR_SIZE});
    err_flag = !in_mem || in_err || oversize || misalign;
    accept   = ahb4_hsel_i && ahb4_hready_i && hreadyout &&
               ((ahb4_htrans_i == HTRANS_NONSEQ) || (ahb4_htrans_i == HTRANS_SEQ));
    commit   = dp_valid && dp_write && (state == RSP_IDLE) && ahb4_hready_i;
  end

  // Responder state, wait counter and error counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RSP_IDLE;
      wait_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_cnt_d;
      if (err_inc && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
    end
  end

  // Next-state and handshake outputs; a new transfer can start from IDLE or the last ERROR cycle.
  always_comb begin
    state_d    = state;
    wait_cnt_d = wait_cnt;
    err_inc    = 1'b0;
    case (state)
      RSP_IDLE, RSP_ERR2: begin
        state_d = RSP_IDLE;
        if (accept) begin
          if (err_flag) begin
            state_d = RSP_ERR1;
            err_inc = 1'b1;
          end else if (WAIT_STATES != 0) begin
            state_d    = RSP_WAIT;
            wait_cnt_d = 4'(WAIT_STATES);
          end
        end
      end
      RSP_WAIT: begin
        if (wait_cnt <= 4'd1) state_d = RSP_IDLE;
        else                  wait_cnt_d = wait_cnt - 4'd1;
      end
      RSP_ERR1: state_d = RSP_ERR2;
      default:  state_d = RSP_IDLE;
    endcase
    hreadyout        = (state == RSP_IDLE) || (state == RSP_ERR2);
    ahb4_hreadyout_o = hreadyout;
    ahb4_hresp_o     = ((state == RSP_ERR1) || (state == RSP_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    err_cnt_o        = err_cnt;
  end

  // Data-phase context, captured whenever the previous data phase completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_be    <= '0;
    end else if (ahb4_hready_i && hreadyout) begin
      dp_valid <= accept && !err_flag;
      dp_write <= ahb4_hwrite_i;
      dp_idx   <= mem_off[OFFW +: IDXW];
      dp_be    <= be;
    end
  end

  // Write data lands on the edge that closes an OKAY write data phase.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < BYTES; b++) begin
        if (dp_be[b]) mem[dp_idx][8*b +: 8] <= ahb4_hwdata_i[8*b +: 8];
      end
    end
  end

  // Read data is only visible in the completing cycle of an OKAY read.
  always_comb begin
    ahb4_hrdata_o = '0;
    if (dp_valid && !dp_write && (state == RSP_IDLE)) ahb4_hrdata_o = mem[dp_idx];
  end

endmodule
